// File: rtl/vga_linebuf.sv
// Scanline source for the VGA timing generator: fetches source lines from a
// framebuffer into a ping-pong line buffer and streams each pixel twice.
module vga_linebuf #(
  parameter int unsigned BPP    = 4,
  parameter int unsigned HPIX   = 320,
  parameter int unsigned VLINES = 240,
  parameter int unsigned AW     = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fr,
  input  logic                 newline,
  input  logic                 advance,
  input  logic [7:0]           line,
  output logic [3*BPP-1:0]     pixel,
  input  logic [AW-1:0]        fb_base,
  output logic                 rd_req,
  output logic [AW-1:0]        rd_addr,
  input  logic                 rd_ack,
  input  logic [3*BPP-1:0]     rd_data,
  output logic                 underrun
);

  localparam int unsigned PW = 3 * BPP;
  localparam int unsigned WW = $clog2(HPIX);
  localparam int unsigned XW = 10;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t            state_q;
  logic [1:0]        tag_v_q;
  logic [1:0][7:0]   tag_l_q;
  logic              front_q, front_d;
  logic              blank_q, blank_d;
  logic              fbank_q;
  logic [7:0]        tgt_q, tgt_d;
  logic [WW-1:0]     w_q;
  logic [XW-1:0]     x_q, x_d;
  logic [AW-1:0]     base_q, base_d;
  logic [AW-1:0]     rd_addr_q, start_addr;
  logic              rd_req_q;
  logic              underrun_q, under_d;
  logic [PW-1:0]     pixel_q;
  logic              front_hit, back_hit, tgt_resident, start, wr_en, last;
  logic [WW-1:0]     rd_idx;

  logic [PW-1:0]     mem0 [HPIX];
  logic [PW-1:0]     mem1 [HPIX];

  assign front_hit    = tag_v_q[front_q] && (tag_l_q[front_q] == line);
  assign back_hit     = tag_v_q[~front_q] && (tag_l_q[~front_q] == line);
  assign tgt_d        = (line < 8'(VLINES - 1)) ? line + 8'd1 : 8'd0;
  assign tgt_resident = (tag_v_q[0] && (tag_l_q[0] == tgt_d)) ||
                        (tag_v_q[1] && (tag_l_q[1] == tgt_d));
  assign start        = newline && (state_q == S_IDLE) && !tgt_resident;
  assign base_d       = fr ? fb_base : base_q;
  // T*HPIX as (T<<8)+(T<<6)
  assign start_addr   = base_d + AW'({tgt_d, 8'h00}) + AW'({tgt_d, 6'h00});
  assign wr_en        = (state_q == S_REQ) && rd_ack;
  assign last         = (w_q == WW'(HPIX - 1));
  assign rd_idx       = x_d[XW-1:1];

  // Display-side bank selection at each newline
  always_comb begin
    front_d = front_q;
    blank_d = blank_q;
    under_d = 1'b0;
    if (newline) begin
      if (line >= 8'(VLINES)) begin
        blank_d = 1'b1;
      end else if (front_hit) begin
        blank_d = 1'b0;
      end else if (back_hit) begin
        front_d = ~front_q;
        blank_d = 1'b0;
      end else begin
        blank_d = 1'b1;
        under_d = 1'b1;
      end
    end
  end

  always_comb begin
    x_d = x_q;
    if (newline) begin
      x_d = '0;
    end else if (advance && (x_q != XW'(2 * HPIX - 1))) begin
      x_d = x_q + XW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (fbank_q) mem1[w_q] <= rd_data;
      else         mem0[w_q] <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tag_v_q    <= '0;
      tag_l_q    <= '0;
      front_q    <= 1'b0;
      blank_q    <= 1'b1;
      fbank_q    <= 1'b0;
      tgt_q      <= '0;
      w_q        <= '0;
      x_q        <= '0;
      base_q     <= '0;
      rd_addr_q  <= '0;
      rd_req_q   <= 1'b0;
      underrun_q <= 1'b0;
      pixel_q    <= '0;
    end else begin
      front_q    <= front_d;
      blank_q    <= blank_d;
      x_q        <= x_d;
      base_q     <= base_d;
      underrun_q <= under_d;
      // RAM read of the following pixel so it is presented in its advance cycle
      pixel_q    <= blank_d ? '0 : (front_d ? mem1[rd_idx] : mem0[rd_idx]);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            tag_v_q[~front_d] <= 1'b0;
            fbank_q           <= ~front_d;
            tgt_q             <= tgt_d;
            w_q               <= '0;
            rd_addr_q         <= start_addr;
            rd_req_q          <= 1'b1;
            state_q           <= S_REQ;
          end
        end
        S_REQ: begin
          if (rd_ack) begin
            w_q       <= w_q + WW'(1);
            rd_addr_q <= rd_addr_q + AW'(1);
            if (last) begin
              rd_req_q          <= 1'b0;
              tag_v_q[fbank_q]  <= 1'b1;
              tag_l_q[fbank_q]  <= tgt_q;
              state_q           <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pixel    = pixel_q;
  assign rd_req   = rd_req_q;
  assign rd_addr  = rd_addr_q;
  assign underrun = underrun_q;

endmodule

// File: doc/vga_linebuf.md
Name: vga_linebuf

Overview:
- Scanline source directly upstream of the VGA timing generator: consumes its newline/advance/line outputs and supplies the pixel word it displays.
- Fetches 320-pixel source lines (RGB, 3*BPP bits each) from a framebuffer memory over a req/ack read port into a ping-pong line buffer.
- Streams each pixel twice horizontally; the timing generator repeats each source line over two scanlines, giving 320x240 on 640x480.

Parameters:
BPP, 4, bits per colour channel; pixel word is 3*BPP bits, {r,g,b} MSB to LSB
HPIX, 320, source pixels per line
VLINES, 240, source lines per frame
AW, 17, framebuffer word-address width (must hold HPIX*VLINES plus base)

Ports:
clk  in  1  pixel clock (25MHz)
rst_n  in  1  asynchronous active-low reset
fr  in  1  one-cycle frame-start pulse from the timing generator
newline  in  1  one-cycle start-of-scanline pulse
advance  in  1  high during active pixels; the pixel output is consumed in every advance cycle
line  in  8  current source line; 0..239 valid, any other value is blanking
pixel  out  3*BPP  pixel for the current advance cycle, registered
fb_base  in  AW  framebuffer base word address, sampled on fr
rd_req  out  1  memory read request
rd_addr  out  AW  read word address, stable while rd_req is high
rd_ack  in  1  read accepted; rd_data is valid in the same cycle
rd_data  in  3*BPP  read data
underrun  out  1  one-cycle pulse when a needed line was not ready at newline

Behaviour:
- Reset values (rst_n low, asynchronous): pixel=0, rd_req=0, rd_addr=0, underrun=0, base=0. Both bank tags invalid; front bank = 0; fetch FSM IDLE; x counter = 0.
- Bank tag per bank: {valid, line[7:0]}. A bank's tag becomes valid only when its final (HPIX-th) word has been written.
- Base register: loads fb_base in the cycle fr=1.
- Newline processing happens in the cycle newline=1. Display side, in priority order:
  - line>=VLINES: front marked blank.
  - Else if the front tag equals line: keep the front bank.
  - Else if the back tag equals line: swap banks.
  - Else: front marked blank and underrun=1 for one cycle.
- Fetch target T = line+1 if line<VLINES-1, else 0 (this includes all blanking values).
- Fetch start: if the FSM is IDLE and no bank's tag already equals T, start a fetch of T into the non-front bank, using the front bank as decided after any swap in the same cycle. That bank's tag is invalidated immediately. A fetch never overwrites the front bank.
- Fetch FSM:
  - IDLE -> REQ. rd_addr = base + T*320, computed as (T<<8)+(T<<6), truncated to AW bits; word index w=0.
  - REQ: rd_req=1. On rd_ack: write rd_data to bank[w], w+1, rd_addr+1. If w==HPIX-1, deassert rd_req, set the tag to {1,T} and go to IDLE.
  - rd_req stays high and rd_addr stays stable between acks. Back-to-back acks give one word per cycle (320 cycles minimum).
- Newline during an active fetch: the fetch continues untouched and no new fetch starts. If that line was the one needed, the display side has already flagged underrun and blanked.
- fr mid-fetch: the fetch completes with the old base; the new base applies to the next fetch.
- Pixel stream:
  - x counter clears on newline and increments on each advance cycle (10 bits, saturates at 639).
  - Buffer read address = x>>1, on synchronous RAM. pixel is registered so that the value present in an advance cycle equals front[x>>1], where x is the number of earlier advance cycles in this line.
  - Prefetch of front[0] completes within 2 cycles of newline. The timing generator keeps at least 140 cycles between newline and the first advance.
  - pixel=0 whenever the front is blank. Outside advance, pixel holds its last value; the timing generator masks it.
- Buffer storage: two banks of HPIX x 3*BPP, one write port (fetch) and one read port (display); the same bank is never read and written at once.

Test Plan:
- Reset mid-fetch: assert rst_n low while rd_req=1 -> rd_req=0, pixel=0, tags invalid; after release, no rd_req until the next newline.
- Steady state, rd_ack always 1, fb_base=0, memory word = address: newline with line=5 -> fetch of line 6 from 1920..2239 completes in 320 cycles. On line=6, pixels run 1920,1920,1921,1921,…,2239,2239 across the 640 advance cycles.
- Repeated line: two consecutive newlines with line=6 -> no bank swap, no second fetch of line 7, identical pixel streams.
- Wrap: line=239 then line=240..245 -> target 0 fetched from base+0. Blanking lines give pixel=0 with no underrun. Line 0 then displays without underrun.
- Slow memory, rd_ack every 8th cycle (>1600 cycles per fetch): newline for an unfetched line -> underrun pulse, pixel=0 for that scanline, fetch not restarted. rd_addr is held stable while unacked.
- Base change: fb_base=0x10000 with fr -> the next fetch of line 0 starts at 0x10000. A fetch already in progress finishes on the old base.
